// File: rtl/icb_arbiter_2to1.sv
// Two-master to one-slave ICB arbiter: round-robin command grant locked until handshake, in-order response routing.
// Latency: zero added cycles on both the command and response paths (pure combinational muxing, registered state).
// Backpressure: slave cmd_ready reaches only the granted master; a full ID FIFO stalls commands, an empty one refuses responses.
module icb_arbiter_2to1 #(
    parameter int OUTSTANDING = 2,
    parameter int CNT_W       = $clog2(OUTSTANDING + 1),
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    // master 0 (cmd in, rsp out)
    input  logic              m0_icb_cmd_valid,
    output logic              m0_icb_cmd_ready,
    input  logic [AW-1:0]     m0_icb_cmd_addr,
    input  logic              m0_icb_cmd_read,
    input  logic [DW-1:0]     m0_icb_cmd_wdata,
    input  logic [DW/8-1:0]   m0_icb_cmd_wmask,
    output logic              m0_icb_rsp_valid,
    input  logic              m0_icb_rsp_ready,
    output logic [DW-1:0]     m0_icb_rsp_rdata,
    output logic              m0_icb_rsp_err,

    // master 1 (cmd in, rsp out)
    input  logic              m1_icb_cmd_valid,
    output logic              m1_icb_cmd_ready,
    input  logic [AW-1:0]     m1_icb_cmd_addr,
    input  logic              m1_icb_cmd_read,
    input  logic [DW-1:0]     m1_icb_cmd_wdata,
    input  logic [DW/8-1:0]   m1_icb_cmd_wmask,
    output logic              m1_icb_rsp_valid,
    input  logic              m1_icb_rsp_ready,
    output logic [DW-1:0]     m1_icb_rsp_rdata,
    output logic              m1_icb_rsp_err,

    // shared slave (cmd out, rsp in)
    output logic              s_icb_cmd_valid,
    input  logic              s_icb_cmd_ready,
    output logic [AW-1:0]     s_icb_cmd_addr,
    output logic              s_icb_cmd_read,
    output logic [DW-1:0]     s_icb_cmd_wdata,
    output logic [DW/8-1:0]   s_icb_cmd_wmask,
    input  logic              s_icb_rsp_valid,
    output logic              s_icb_rsp_ready,
    input  logic [DW-1:0]     s_icb_rsp_rdata,
    input  logic              s_icb_rsp_err,

    // status
    output logic [CNT_W-1:0]  outstanding_cnt,
    output logic              grant_id,
    output logic              err_unexp_rsp
);

    localparam int                PTR_W    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(OUTSTANDING - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(OUTSTANDING);

    // arbitration state
    logic             prio_q;
    logic             lock_q;
    logic             locked_id_q;
    logic             err_q;

    // ID FIFO: one entry per accepted command, holding the issuing master
    logic             id_mem [OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             head;

    logic             grant;
    logic             grant_vld;
    logic             cmd_rdy;
    logic             cmd_hs;
    logic             rsp_fwd;
    logic             rsp_hs;

    assign fifo_full  = (cnt_q == FULL_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign head       = id_mem[rd_ptr_q];

    // Grant selection: a locked grant holds, a lone requester wins, otherwise the priority pointer decides
    always_comb begin
        grant = prio_q;
        if (lock_q) begin
            grant = locked_id_q;
        end else if (m0_icb_cmd_valid ^ m1_icb_cmd_valid) begin
            grant = m1_icb_cmd_valid;
        end
    end

    assign grant_vld = grant ? m1_icb_cmd_valid : m0_icb_cmd_valid;

    // Command path: the granted master drives the slave; a full FIFO hides both valid and ready
    assign s_icb_cmd_valid  = rst_n & grant_vld & ~fifo_full;
    assign cmd_rdy          = rst_n & s_icb_cmd_ready & ~fifo_full;
    assign m0_icb_cmd_ready = cmd_rdy & ~grant;
    assign m1_icb_cmd_ready = cmd_rdy & grant;
    assign s_icb_cmd_addr   = grant ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign s_icb_cmd_read   = grant ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign s_icb_cmd_wdata  = grant ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign s_icb_cmd_wmask  = grant ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
    assign cmd_hs           = s_icb_cmd_valid & s_icb_cmd_ready;

    // Response path: only the FIFO head master sees the response; with no entry nothing is forwarded
    assign rsp_fwd          = rst_n & ~fifo_empty;
    assign m0_icb_rsp_valid = rsp_fwd & ~head & s_icb_rsp_valid;
    assign m1_icb_rsp_valid = rsp_fwd &  head & s_icb_rsp_valid;
    assign m0_icb_rsp_rdata = (rsp_fwd & ~head) ? s_icb_rsp_rdata : '0;
    assign m1_icb_rsp_rdata = (rsp_fwd &  head) ? s_icb_rsp_rdata : '0;
    assign m0_icb_rsp_err   = rsp_fwd & ~head & s_icb_rsp_err;
    assign m1_icb_rsp_err   = rsp_fwd &  head & s_icb_rsp_err;
    assign s_icb_rsp_ready  = rsp_fwd & (head ? m1_icb_rsp_ready : m0_icb_rsp_ready);
    assign rsp_hs           = s_icb_rsp_valid & s_icb_rsp_ready;

    assign outstanding_cnt  = cnt_q;
    assign grant_id         = rst_n & grant;
    assign err_unexp_rsp    = err_q;

    // Arbitration state: lock a presented-but-unaccepted grant, rotate priority on each accepted command
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q      <= 1'b0;
            lock_q      <= 1'b0;
            locked_id_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (cmd_hs) begin
                lock_q <= 1'b0;
                prio_q <= ~grant;
            end else if (grant_vld) begin
                lock_q      <= 1'b1;
                locked_id_q <= grant;
            end
            if (s_icb_rsp_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    // ID FIFO pointers and occupancy; push and pop in the same cycle leave the count unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (cmd_hs) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (rsp_hs) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (cmd_hs && !rsp_hs) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (rsp_hs && !cmd_hs) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // ID FIFO storage: record which master issued each accepted command
    always_ff @(posedge clk) begin
        if (cmd_hs) begin
            id_mem[wr_ptr_q] <= grant;
        end
    end

endmodule

// File: tb/tb_icb_arbiter_2to1.sv
module tb_icb_arbiter_2to1;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
    logic [31:0] m0_icb_cmd_addr, m0_icb_cmd_wdata;
    logic [3:0]  m0_icb_cmd_wmask;
    logic        m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
    logic [31:0] m0_icb_rsp_rdata;

    logic        m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
    logic [31:0] m1_icb_cmd_addr, m1_icb_cmd_wdata;
    logic [3:0]  m1_icb_cmd_wmask;
    logic        m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
    logic [31:0] m1_icb_rsp_rdata;

    logic        s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
    logic [31:0] s_icb_cmd_addr, s_icb_cmd_wdata;
    logic [3:0]  s_icb_cmd_wmask;
    logic        s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
    logic [31:0] s_icb_rsp_rdata;

    logic [1:0]  outstanding_cnt;
    logic        grant_id;
    logic        err_unexp_rsp;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    icb_arbiter_2to1 #(.OUTSTANDING(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .m0_icb_cmd_valid (m0_icb_cmd_valid),
        .m0_icb_cmd_ready (m0_icb_cmd_ready),
        .m0_icb_cmd_addr  (m0_icb_cmd_addr),
        .m0_icb_cmd_read  (m0_icb_cmd_read),
        .m0_icb_cmd_wdata (m0_icb_cmd_wdata),
        .m0_icb_cmd_wmask (m0_icb_cmd_wmask),
        .m0_icb_rsp_valid (m0_icb_rsp_valid),
        .m0_icb_rsp_ready (m0_icb_rsp_ready),
        .m0_icb_rsp_rdata (m0_icb_rsp_rdata),
        .m0_icb_rsp_err   (m0_icb_rsp_err),
        .m1_icb_cmd_valid (m1_icb_cmd_valid),
        .m1_icb_cmd_ready (m1_icb_cmd_ready),
        .m1_icb_cmd_addr  (m1_icb_cmd_addr),
        .m1_icb_cmd_read  (m1_icb_cmd_read),
        .m1_icb_cmd_wdata (m1_icb_cmd_wdata),
        .m1_icb_cmd_wmask (m1_icb_cmd_wmask),
        .m1_icb_rsp_valid (m1_icb_rsp_valid),
        .m1_icb_rsp_ready (m1_icb_rsp_ready),
        .m1_icb_rsp_rdata (m1_icb_rsp_rdata),
        .m1_icb_rsp_err   (m1_icb_rsp_err),
        .s_icb_cmd_valid  (s_icb_cmd_valid),
        .s_icb_cmd_ready  (s_icb_cmd_ready),
        .s_icb_cmd_addr   (s_icb_cmd_addr),
        .s_icb_cmd_read   (s_icb_cmd_read),
        .s_icb_cmd_wdata  (s_icb_cmd_wdata),
        .s_icb_cmd_wmask  (s_icb_cmd_wmask),
        .s_icb_rsp_valid  (s_icb_rsp_valid),
        .s_icb_rsp_ready  (s_icb_rsp_ready),
        .s_icb_rsp_rdata  (s_icb_rsp_rdata),
        .s_icb_rsp_err    (s_icb_rsp_err),
        .outstanding_cnt  (outstanding_cnt),
        .grant_id         (grant_id),
        .err_unexp_rsp    (err_unexp_rsp)
    );

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_icb_cmd_valid = 0; m0_icb_cmd_read = 0; m0_icb_cmd_addr = 32'h100;
        m0_icb_cmd_wdata = 0; m0_icb_cmd_wmask = 0; m0_icb_rsp_ready = 0;
        m1_icb_cmd_valid = 0; m1_icb_cmd_read = 0; m1_icb_cmd_addr = 32'h200;
        m1_icb_cmd_wdata = 0; m1_icb_cmd_wmask = 0; m1_icb_rsp_ready = 0;
        s_icb_cmd_ready = 0; s_icb_rsp_valid = 0; s_icb_rsp_rdata = 0; s_icb_rsp_err = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        m0_icb_cmd_valid = 1; m1_icb_cmd_valid = 1; s_icb_cmd_ready = 1;
        s_icb_rsp_valid = 1; m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1;
        #1;
        total++; if (s_icb_cmd_valid !== 1'b0) $display("FAIL rst_s_cmd_valid got %b want 0", s_icb_cmd_valid); else pass_cnt++;
        total++; if ({m0_icb_cmd_ready, m1_icb_cmd_ready} !== 2'b00) $display("FAIL rst_m_cmd_ready got %b want 00", {m0_icb_cmd_ready, m1_icb_cmd_ready}); else pass_cnt++;
        total++; if ({m0_icb_rsp_valid, m1_icb_rsp_valid, s_icb_rsp_ready} !== 3'b000) $display("FAIL rst_rsp got %b want 000", {m0_icb_rsp_valid, m1_icb_rsp_valid, s_icb_rsp_ready}); else pass_cnt++;
        step();
        total++; if (outstanding_cnt !== 2'd0) $display("FAIL rst_cnt got %0d want 0", outstanding_cnt); else pass_cnt++;
        total++; if (err_unexp_rsp !== 1'b0) $display("FAIL rst_err got %b want 0", err_unexp_rsp); else pass_cnt++;
        total++; if (grant_id !== 1'b0) $display("FAIL rst_grant got %b want 0", grant_id); else pass_cnt++;
        idle();
        rst_n = 1;
        step();
        total++; if (grant_id !== 1'b0) $display("FAIL rst_prio_grant got %b want 0", grant_id); else pass_cnt++;
    endtask

    task automatic test_single();
        do_reset();
        m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h1000; m0_icb_cmd_wdata = 32'hDEADBEEF;
        m0_icb_cmd_wmask = 4'hF; m0_icb_cmd_read = 0; s_icb_cmd_ready = 1;
        #1;
        total++; if ({s_icb_cmd_valid, s_icb_cmd_read} !== 2'b10) $display("FAIL single_valid_read got %b want 10", {s_icb_cmd_valid, s_icb_cmd_read}); else pass_cnt++;
        total++; if (s_icb_cmd_addr !== 32'h1000) $display("FAIL single_addr got %h want 00001000", s_icb_cmd_addr); else pass_cnt++;
        total++; if (s_icb_cmd_wdata !== 32'hDEADBEEF) $display("FAIL single_wdata got %h want deadbeef", s_icb_cmd_wdata); else pass_cnt++;
        total++; if (s_icb_cmd_wmask !== 4'hF) $display("FAIL single_wmask got %h want f", s_icb_cmd_wmask); else pass_cnt++;
        total++; if ({m0_icb_cmd_ready, m1_icb_cmd_ready} !== 2'b10) $display("FAIL single_cmd_ready got %b want 10", {m0_icb_cmd_ready, m1_icb_cmd_ready}); else pass_cnt++;
        step();
        m0_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
        #1;
        total++; if (outstanding_cnt !== 2'd1) $display("FAIL single_cnt1 got %0d want 1", outstanding_cnt); else pass_cnt++;
        s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'h0; s_icb_rsp_err = 0;
        m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1;
        #1;
        total++; if ({m0_icb_rsp_valid, m1_icb_rsp_valid, s_icb_rsp_ready} !== 3'b101) $display("FAIL single_rsp_route got %b want 101", {m0_icb_rsp_valid, m1_icb_rsp_valid, s_icb_rsp_ready}); else pass_cnt++;
        total++; if (m0_icb_rsp_err !== 1'b0) $display("FAIL single_rsp_err got %b want 0", m0_icb_rsp_err); else pass_cnt++;
        step();
        s_icb_rsp_valid = 0;
        #1;
        total++; if (outstanding_cnt !== 2'd0) $display("FAIL single_cnt0 got %0d want 0", outstanding_cnt); else pass_cnt++;
    endtask

    // both masters request every cycle; the response for command k is returned while command k+1 issues
    task automatic test_contention();
        logic [31:0] exp_rdata;
        logic        dest;
        do_reset();
        s_icb_cmd_ready = 1; m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1;
        m0_icb_cmd_addr = 32'h100; m1_icb_cmd_addr = 32'h200;
        for (int i = 0; i < 5; i++) begin
            m0_icb_cmd_valid = (i < 4);
            m1_icb_cmd_valid = (i < 4);
            s_icb_rsp_valid  = (i >= 1);
            exp_rdata        = 32'(32'hA0 + i - 1);
            s_icb_rsp_rdata  = exp_rdata;
            #1;
            if (i < 4) begin
                total++; if (grant_id !== i[0]) $display("FAIL cont_grant[%0d] got %b want %b", i, grant_id, i[0]); else pass_cnt++;
                total++; if (s_icb_cmd_addr !== (i[0] ? 32'h200 : 32'h100)) $display("FAIL cont_addr[%0d] got %h", i, s_icb_cmd_addr); else pass_cnt++;
            end
            if (i >= 1) begin
                dest = ~i[0];
                total++; if ({m1_icb_rsp_valid, m0_icb_rsp_valid} !== (dest ? 2'b10 : 2'b01)) $display("FAIL cont_rsp_route[%0d] got m1=%b m0=%b want dest m%0d", i, m1_icb_rsp_valid, m0_icb_rsp_valid, dest); else pass_cnt++;
                total++; if ((dest ? m1_icb_rsp_rdata : m0_icb_rsp_rdata) !== exp_rdata) $display("FAIL cont_rdata[%0d] got %h want %h", i, dest ? m1_icb_rsp_rdata : m0_icb_rsp_rdata, exp_rdata); else pass_cnt++;
                total++; if (outstanding_cnt !== 2'd1) $display("FAIL cont_cnt[%0d] got %0d want 1", i, outstanding_cnt); else pass_cnt++;
            end
            step();
        end
        idle();
        #1;
        total++; if (outstanding_cnt !== 2'd0) $display("FAIL cont_cnt_end got %0d want 0", outstanding_cnt); else pass_cnt++;
    endtask

    task automatic test_lock();
        do_reset();
        m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h300; m0_icb_cmd_addr = 32'h100;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) m0_icb_cmd_valid = 1;
            #1;
            total++; if (grant_id !== 1'b1) $display("FAIL lock_grant[%0d] got %b want 1", c, grant_id); else pass_cnt++;
            total++; if (s_icb_cmd_addr !== 32'h300 || s_icb_cmd_valid !== 1'b1) $display("FAIL lock_fields[%0d] got addr %h valid %b want 300/1", c, s_icb_cmd_addr, s_icb_cmd_valid); else pass_cnt++;
            step();
        end
        s_icb_cmd_ready = 1;
        #1;
        total++; if ({m0_icb_cmd_ready, m1_icb_cmd_ready} !== 2'b01) $display("FAIL lock_hs_ready got %b want 01", {m0_icb_cmd_ready, m1_icb_cmd_ready}); else pass_cnt++;
        step();
        m1_icb_cmd_valid = 0;
        #1;
        total++; if (grant_id !== 1'b0 || s_icb_cmd_addr !== 32'h100) $display("FAIL lock_next_grant got %b addr %h want 0/100", grant_id, s_icb_cmd_addr); else pass_cnt++;
        total++; if (m0_icb_cmd_ready !== 1'b1) $display("FAIL lock_next_ready got %b want 1", m0_icb_cmd_ready); else pass_cnt++;
        step();
        idle();
    endtask

    task automatic test_full();
        do_reset();
        m0_icb_cmd_valid = 1; s_icb_cmd_ready = 1;
        step();
        step();
        m0_icb_cmd_addr = 32'h500;
        #1;
        total++; if (s_icb_cmd_valid !== 1'b0) $display("FAIL full_cmd_valid got %b want 0", s_icb_cmd_valid); else pass_cnt++;
        total++; if (outstanding_cnt !== 2'd2) $display("FAIL full_cnt got %0d want 2", outstanding_cnt); else pass_cnt++;
        total++; if (m0_icb_cmd_ready !== 1'b0) $display("FAIL full_cmd_ready got %b want 0", m0_icb_cmd_ready); else pass_cnt++;
        step();
        s_icb_rsp_valid = 1; m0_icb_rsp_ready = 1;
        #1;
        total++; if ({s_icb_rsp_ready, m0_icb_rsp_valid} !== 2'b11) $display("FAIL full_rsp got %b want 11", {s_icb_rsp_ready, m0_icb_rsp_valid}); else pass_cnt++;
        total++; if (s_icb_cmd_valid !== 1'b0) $display("FAIL full_same_cycle got %b want 0", s_icb_cmd_valid); else pass_cnt++;
        step();
        s_icb_rsp_valid = 0;
        #1;
        total++; if ({s_icb_cmd_valid, m0_icb_cmd_ready} !== 2'b11) $display("FAIL full_next_cycle got %b want 11", {s_icb_cmd_valid, m0_icb_cmd_ready}); else pass_cnt++;
        total++; if (outstanding_cnt !== 2'd1) $display("FAIL full_cnt_after_pop got %0d want 1", outstanding_cnt); else pass_cnt++;
        step();
        m0_icb_cmd_valid = 0;
        #1;
        total++; if (outstanding_cnt !== 2'd2) $display("FAIL full_cnt_refill got %0d want 2", outstanding_cnt); else pass_cnt++;
        idle();
    endtask

    task automatic test_unexpected_reset();
        do_reset();
        s_icb_rsp_valid = 1; m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1;
        #1;
        total++; if ({s_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid} !== 3'b000) $display("FAIL unexp_block got %b want 000", {s_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid}); else pass_cnt++;
        step();
        s_icb_rsp_valid = 0;
        #1;
        total++; if (err_unexp_rsp !== 1'b1) $display("FAIL unexp_err_set got %b want 1", err_unexp_rsp); else pass_cnt++;
        // one m0 command moves priority to m1 and leaves an entry outstanding
        m0_icb_cmd_valid = 1; s_icb_cmd_ready = 1;
        step();
        m0_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
        #1;
        total++; if (err_unexp_rsp !== 1'b1 || outstanding_cnt !== 2'd1) $display("FAIL unexp_sticky got err %b cnt %0d want 1/1", err_unexp_rsp, outstanding_cnt); else pass_cnt++;
        rst_n = 0;
        step();
        rst_n = 1;
        m0_icb_cmd_valid = 1; m1_icb_cmd_valid = 1;
        #1;
        total++; if (err_unexp_rsp !== 1'b0) $display("FAIL unexp_err_clear got %b want 0", err_unexp_rsp); else pass_cnt++;
        total++; if (outstanding_cnt !== 2'd0) $display("FAIL unexp_cnt_clear got %0d want 0", outstanding_cnt); else pass_cnt++;
        total++; if (grant_id !== 1'b0) $display("FAIL unexp_prio_clear got %b want 0", grant_id); else pass_cnt++;
        m0_icb_cmd_valid = 0; m1_icb_cmd_valid = 0;
        s_icb_rsp_valid = 1;
        #1;
        total++; if ({s_icb_rsp_ready, m0_icb_rsp_valid} !== 2'b00) $display("FAIL unexp_after_rst got %b want 00", {s_icb_rsp_ready, m0_icb_rsp_valid}); else pass_cnt++;
        idle();
    endtask

    initial begin
        rst_n = 0;
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_full();
        test_unexpected_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout: %0d/%0d checks done", pass_cnt, total);
        $fatal(1, "timeout");
    end

endmodule
